shift_pipe: RTL and testbench

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pkg.sv | 28 ++
 rtl/shift_level.sv | 35 +++
 rtl/shift_pipe.sv | 176 +++++++++++++++++
 tb/tb_shift_pipe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg : mode encodings and width helper for the shift_pipe slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shift_pkg;

  typedef enum logic [2:0] {
    MODE_SLL = 3'b000,
    MODE_SRL = 3'b001,
    MODE_SRA = 3'b011,
    MODE_ROL = 3'b100,
    MODE_ROR = 3'b101
  } mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_level.sv
// ---------------------------------------------------------------------------
// shift_level : one binary barrel level (left shift or left rotate by 2^LEVEL)
// Rev 1.0 -- rotate path present only with SHIFT_PIPE_ROTATE_EN
// ---------------------------------------------------------------------------
`default_nettype none

module shift_level #(
  parameter int WIDTH = 32,
  parameter int LEVEL = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             amt_i,
  input  logic             fill_i,
  input  logic             rot_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int SH = 1 << LEVEL;

  logic [WIDTH-1:0] shifted;

`ifdef SHIFT_PIPE_ROTATE_EN
  assign shifted = rot_i ? {data_i[WIDTH-SH-1:0], data_i[WIDTH-1:WIDTH-SH]}
                         : {data_i[WIDTH-SH-1:0], {SH{fill_i}}};
`else
  logic unused_rot;
  assign unused_rot = rot_i;
  assign shifted    = {data_i[WIDTH-SH-1:0], {SH{fill_i}}};
`endif

  assign data_o = amt_i ? shifted : data_i;

endmodule

`default_nettype wire

// File: rtl/shift_pipe.sv
// ---------------------------------------------------------------------------
// shift_pipe : valid/ready pipelined barrel shifter over LAT register stages
// Rev 1.0 -- ROL/ROR enabled by SHIFT_PIPE_ROTATE_EN
// ---------------------------------------------------------------------------
`default_nettype none

module shift_pipe
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int LAT   = 2,
  localparam int BW    = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [BW-1:0]    B,
  input  logic [2:0]       Mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Err
);

  localparam int LEVELS = BW;
  localparam int PER    = (LEVELS + LAT - 1) / LAT;

  logic [WIDTH-1:0] a_rev;
  logic [WIDTH-1:0] dec_data;
  logic [BW-1:0]    dec_amt;
  logic             dec_fill, dec_rot, dec_rev, dec_err;

  assign a_rev = {<<{A}};

  // Right shifts run on the bit-reversed operand through the left datapath
  // and are reversed back in front of the output register.
  always_comb begin
    dec_amt  = B;
    dec_fill = 1'b0;
    dec_rot  = 1'b0;
    dec_rev  = 1'b0;
    dec_err  = 1'b0;
    case (Mode)
      MODE_SLL: dec_rev = 1'b0;
      MODE_SRL: dec_rev = 1'b1;
      MODE_SRA: begin
        dec_rev  = 1'b1;
        dec_fill = A[WIDTH-1];
      end
`ifdef SHIFT_PIPE_ROTATE_EN
      MODE_ROL: dec_rot = 1'b1;
      MODE_ROR: begin
        dec_rot = 1'b1;
        dec_rev = 1'b1;
      end
`endif
      default: begin
        dec_err = 1'b1;
        dec_amt = '0;
      end
    endcase
    dec_data = dec_rev ? a_rev : A;
  end

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam int FIRST = s * PER;
    localparam int NLVL  = (FIRST >= LEVELS) ? 0 :
                           ((LEVELS - FIRST < PER) ? (LEVELS - FIRST) : PER);

    logic [WIDTH-1:0] chain [NLVL+1];
    logic [WIDTH-1:0] data_d;
    logic [BW-1:0]    amt_s;
    logic             fill_s, rot_s, rev_s, err_s, up_valid, dn_adv, adv;
    logic [WIDTH-1:0] data_q;
    logic             err_q, valid_q;

    if (s == 0) begin : g_src_in
      assign chain[0] = dec_data;
      assign amt_s    = dec_amt;
      assign fill_s   = dec_fill;
      assign rot_s    = dec_rot;
      assign rev_s    = dec_rev;
      assign err_s    = dec_err;
      assign up_valid = in_valid;
    end else begin : g_src_prev
      assign chain[0] = g_stage[s-1].data_q;
      assign amt_s    = g_stage[s-1].g_mid.amt_q;
      assign fill_s   = g_stage[s-1].g_mid.fill_q;
      assign rot_s    = g_stage[s-1].g_mid.rot_q;
      assign rev_s    = g_stage[s-1].g_mid.rev_q;
      assign err_s    = g_stage[s-1].err_q;
      assign up_valid = g_stage[s-1].valid_q;
    end

    if (s == LAT - 1) begin : g_dn_out
      assign dn_adv = out_ready;
    end else begin : g_dn_next
      assign dn_adv = g_stage[s+1].adv;
    end

    assign adv = !valid_q || dn_adv;

    for (genvar j = 0; j < NLVL; j++) begin : g_level
      shift_level #(
        .WIDTH (WIDTH),
        .LEVEL (LEVELS - 1 - FIRST - j)
      ) u_level (
        .data_i (chain[j]),
        .amt_i  (amt_s[LEVELS-1-FIRST-j]),
        .fill_i (fill_s),
        .rot_i  (rot_s),
        .data_o (chain[j+1])
      );
    end

    if (s == LAT - 1) begin : g_out
      logic [WIDTH-1:0] data_rev;
      logic             zero_q;
      logic             unused_ctl;

      assign data_rev   = {<<{chain[NLVL]}};
      assign data_d     = rev_s ? data_rev : chain[NLVL];
      assign unused_ctl = ^{amt_s, fill_s, rot_s};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                zero_q <= 1'b0;
        else if (adv && up_valid)  zero_q <= (data_d == '0);
      end
    end else begin : g_mid
      logic [BW-1:0] amt_q;
      logic          fill_q, rot_q, rev_q;

      assign data_d = chain[NLVL];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_q  <= '0;
          fill_q <= 1'b0;
          rot_q  <= 1'b0;
          rev_q  <= 1'b0;
        end else if (adv && up_valid) begin
          amt_q  <= amt_s;
          fill_q <= fill_s;
          rot_q  <= rot_s;
          rev_q  <= rev_s;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        err_q   <= 1'b0;
      end else if (adv) begin
        valid_q <= up_valid;
        if (up_valid) begin
          data_q <= data_d;
          err_q  <= err_s;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].adv;
  assign out_valid = g_stage[LAT-1].valid_q;
  assign Result    = g_stage[LAT-1].data_q;
  assign Err       = g_stage[LAT-1].err_q;
  assign Zero      = g_stage[LAT-1].g_out.zero_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_pipe : directed and random checks of shift_pipe against a queue model
// Rev 1.0 -- rotate expectations follow SHIFT_PIPE_ROTATE_EN
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_pipe;

  localparam int W   = 32;
  localparam int LAT = 2;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         err;
  } exp_t;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, Zero, Err;
  logic [W-1:0] A, Result;
  logic [4:0]   B;
  logic [2:0]   Mode;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_out    = 0;

  exp_t         exp_q[$];
  logic         stalled = 1'b0;
  logic [W-1:0] held_res;
  logic         held_zero, held_err;

  shift_pipe #(.WIDTH(W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Mode      (Mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .Err       (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the shift definitions.
  function automatic exp_t model(input logic [W-1:0] a, input logic [4:0] b, input logic [2:0] m);
    exp_t         e;
    logic [W-1:0] r;
    int           n;
    n     = int'(b);
    e.err = 1'b0;
    case (m)
      3'b000: r = a << n;
      3'b001: r = a >> n;
      3'b011: r = W'($signed(a) >>> n);
`ifdef SHIFT_PIPE_ROTATE_EN
      3'b100: r = (n == 0) ? a : ((a << n) | (a >> (W - n)));
      3'b101: r = (n == 0) ? a : ((a >> n) | (a << (W - n)));
`endif
      default: begin
        r     = a;
        e.err = 1'b1;
      end
    endcase
    e.res  = r;
    e.zero = (r == '0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid",  64'(out_valid), 64'(1));
        check("stall_result", 64'(Result),    64'(held_res));
        check("stall_zero",   64'(Zero),      64'(held_zero));
        check("stall_err",    64'(Err),       64'(held_err));
      end
      if (out_valid && out_ready) begin
        check("out_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_result", 64'(Result), 64'(e.res));
          check("sb_zero",   64'(Zero),   64'(e.zero));
          check("sb_err",    64'(Err),    64'(e.err));
        end
        n_out++;
      end
      stalled   = out_valid && !out_ready;
      held_res  = Result;
      held_zero = Zero;
      held_err  = Err;
      if (in_valid && in_ready) exp_q.push_back(model(A, B, Mode));
    end
  end

  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [4:0] b,
                         input logic [2:0] m, input logic [W-1:0] er, input logic ez,
                         input logic ee);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A = a; B = b; Mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat),    64'(LAT));
    check({tag, "_result"},  64'(Result), 64'(er));
    check({tag, "_zero"},    64'(Zero),   64'(ez));
    check({tag, "_err"},     64'(Err),    64'(ee));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n0, sent, i;
    logic saw_full;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Mode = '0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_result",    64'(Result),    64'(0));
    check("rst_zero",      64'(Zero),      64'(0));
    check("rst_err",       64'(Err),       64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_one("sll4",   32'h8000_0001, 5'd4,  3'b000, 32'h0000_0010, 1'b0, 1'b0);
    run_one("sra31",  32'h8000_0000, 5'd31, 3'b011, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_one("srl31",  32'h8000_0000, 5'd31, 3'b001, 32'h0000_0001, 1'b0, 1'b0);
`ifdef SHIFT_PIPE_ROTATE_EN
    run_one("ror8",   32'h1234_5678, 5'd8,  3'b101, 32'h7812_3456, 1'b0, 1'b0);
    run_one("rol8",   32'h1234_5678, 5'd8,  3'b100, 32'h3456_7812, 1'b0, 1'b0);
`else
    run_one("ror_off", 32'h1234_5678, 5'd8, 3'b101, 32'h1234_5678, 1'b0, 1'b1);
`endif
    run_one("ill111", 32'hDEAD_BEEF, 5'd5,  3'b111, 32'hDEAD_BEEF, 1'b0, 1'b1);
    run_one("srlzero", 32'h0000_0001, 5'd1, 3'b001, 32'h0000_0000, 1'b1, 1'b0);
    run_one("sra_b0", 32'h8765_4321, 5'd0,  3'b011, 32'h8765_4321, 1'b0, 1'b0);

    // Eight back-to-back beats with the consumer stalled in cycles 3..6.
    n0 = n_out; i = 0; saw_full = 1'b0;
    for (int c = 0; c < 60 && (n_out - n0) < 8; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (i < 8);
      A    = 32'h1111_1111 * 32'(i + 1);
      B    = 5'(i);
      Mode = 3'b000;
      @(negedge clk);
      if (in_valid && !in_ready) saw_full = 1'b1;
      if (in_valid && in_ready) i++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("b2b_count",    64'(n_out - n0),   64'(8));
    check("b2b_full",     64'(saw_full),     64'(1));
    check("b2b_drained",  64'(exp_q.size()), 64'(0));

    // Reset with two beats in flight.
    out_ready = 1'b0; in_valid = 1'b1; Mode = 3'b000;
    A = 32'h0000_00F0; B = 5'd1;
    @(posedge clk); #1;
    A = 32'h0000_0F00; B = 5'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready",  64'(in_ready),  64'(1));
    check("midrst_result",    64'(Result),    64'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("no_stale", 64'(out_valid), 64'(0));
    end
    run_one("postrst", 32'h0000_00FF, 5'd8, 3'b000, 32'h0000_FF00, 1'b0, 1'b0);

    // Random traffic with random backpressure against the model.
    n0 = n_out; sent = 0;
    for (int k = 0; k < 3000 && sent < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      A         = $urandom;
      B         = 5'($urandom_range(0, 31));
      Mode      = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("rand_drained", 64'(exp_q.size()), 64'(0));
    check("rand_count",   64'(n_out - n0),   64'(sent));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
